// File: rtl/minesweeper_pkg.sv
// Shared types and constants for the minesweeper board builder.
// The state enum, default board geometry, and LFSR taps/seed are kept here so they have one definition.
package minesweeper_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_HEIGHT = 8;
    localparam int DEFAULT_MINES  = 10;

    // Feedback taps 16,14,13,11 expressed as a mask on state bits [15:0]
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PICK,
        CHECK,
        PLACE,
        SCAN,
        FINISH
    } placer_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR that shifts left.
// A load takes priority over a step, and reset returns the register to the default seed.
module lfsr16
    import minesweeper_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_value;
        end else if (step) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LFSR_DEFAULT_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/mine_placer.sv
// Places MINES random mines on a WIDTH x HEIGHT board, then scans every cell to drive adjacent-count increments.
// Optional macro SAFE_FIRST_CLICK_EN adds safeX/safeY; the cell they name is never chosen as a mine.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | one-cycle clear of both boards
// PICK   | take a candidate cell from the LFSR, then step it
// CHECK  | read the candidate; reject it if out of range, already mined or the safe cell
// PLACE  | write the mine and count it
// SCAN   | visit each cell row-major; each mine pulses incAdjacent
// FINISH | one-cycle done pulse
module mine_placer
    import minesweeper_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    parameter  int HEIGHT = DEFAULT_HEIGHT,
    parameter  int MINES  = DEFAULT_MINES,
    localparam int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [15:0]   seed,
`ifdef SAFE_FIRST_CLICK_EN
    input  logic [XW-1:0] safeX,
    input  logic [YW-1:0] safeY,
`endif
    output logic          busy,
    output logic          done,
    output logic          boardClear,
    output logic [XW-1:0] readX,
    output logic [YW-1:0] readY,
    input  logic          mineReadValue,
    output logic [XW-1:0] writeX,
    output logic [YW-1:0] writeY,
    output logic          mineWriteEn,
    output logic          incAdjacent
);

    localparam int PW = $clog2(MINES + 1);
    localparam logic [XW:0]   WIDTH_L  = (XW + 1)'(WIDTH);
    localparam logic [YW:0]   HEIGHT_L = (YW + 1)'(HEIGHT);
    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [PW-1:0] MINES_L  = PW'(MINES);

    generate
        if (MINES < 1 || MINES > WIDTH * HEIGHT - 2) begin : g_bad_mines
            $error("mine_placer: MINES must be in 1 .. WIDTH*HEIGHT-2");
        end
        if (XW + YW > 16) begin : g_bad_geometry
            $error("mine_placer: board coordinates wider than the 16-bit LFSR");
        end
    endgenerate

    placer_state_t state_q, state_d;

    logic [XW-1:0] cand_x_q, cand_x_d;
    logic [YW-1:0] cand_y_q, cand_y_d;
    logic [XW-1:0] rd_x_q, rd_x_d;
    logic [YW-1:0] rd_y_q, rd_y_d;
    logic [XW-1:0] wr_x_q, wr_x_d;
    logic [YW-1:0] wr_y_q, wr_y_d;
    logic [PW-1:0] placed_q, placed_d;

    logic          lfsr_load;
    logic          lfsr_step;
    logic [15:0]   lfsr_seed;
    logic [15:0]   lfsr_state;

    logic          cand_reject;
    logic          cand_is_safe;
    logic          last_mine;
    logic          scan_last;
    logic [XW-1:0] scan_x_next;
    logic [YW-1:0] scan_y_next;

`ifdef SAFE_FIRST_CLICK_EN
    logic [XW-1:0] safe_x_q, safe_x_d;
    logic [YW-1:0] safe_y_q, safe_y_d;

    assign cand_is_safe = (cand_x_q == safe_x_q) && (cand_y_q == safe_y_q);
`else
    assign cand_is_safe = 1'b0;
`endif

    assign lfsr_seed = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;

    lfsr16 u_lfsr (
        .clk        (clk),
        .rst        (reset),
        .load       (lfsr_load),
        .load_value (lfsr_seed),
        .step       (lfsr_step),
        .state      (lfsr_state)
    );

    // In CHECK the read address already holds the candidate, so mineReadValue refers to that cell.
    assign cand_reject = ({1'b0, cand_x_q} >= WIDTH_L) || ({1'b0, cand_y_q} >= HEIGHT_L)
                       || mineReadValue || cand_is_safe;
    assign last_mine   = (placed_q + 1'b1) == MINES_L;
    assign scan_last   = (rd_x_q == X_LAST) && (rd_y_q == Y_LAST);

    always_comb begin
        scan_x_next = rd_x_q + 1'b1;
        scan_y_next = rd_y_q;
        if (rd_x_q == X_LAST) begin
            scan_x_next = '0;
            scan_y_next = rd_y_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cand_x_q <= '0;
            cand_y_q <= '0;
            rd_x_q   <= '0;
            rd_y_q   <= '0;
            wr_x_q   <= '0;
            wr_y_q   <= '0;
            placed_q <= '0;
`ifdef SAFE_FIRST_CLICK_EN
            safe_x_q <= '0;
            safe_y_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            rd_x_q   <= rd_x_d;
            rd_y_q   <= rd_y_d;
            wr_x_q   <= wr_x_d;
            wr_y_q   <= wr_y_d;
            placed_q <= placed_d;
`ifdef SAFE_FIRST_CLICK_EN
            safe_x_q <= safe_x_d;
            safe_y_q <= safe_y_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = PICK;
            PICK:    state_d = CHECK;
            CHECK:   state_d = cand_reject ? PICK : PLACE;
            PLACE:   state_d = last_mine ? SCAN : PICK;
            SCAN:    if (scan_last) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        rd_x_d    = rd_x_q;
        rd_y_d    = rd_y_q;
        wr_x_d    = wr_x_q;
        wr_y_d    = wr_y_q;
        placed_d  = placed_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
`ifdef SAFE_FIRST_CLICK_EN
        safe_x_d  = safe_x_q;
        safe_y_d  = safe_y_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    placed_d  = '0;
`ifdef SAFE_FIRST_CLICK_EN
                    safe_x_d  = safeX;
                    safe_y_d  = safeY;
`endif
                end
            end
            PICK: begin
                cand_x_d  = lfsr_state[XW-1:0];
                cand_y_d  = lfsr_state[XW+YW-1:XW];
                rd_x_d    = lfsr_state[XW-1:0];
                rd_y_d    = lfsr_state[XW+YW-1:XW];
                lfsr_step = 1'b1;
            end
            CHECK: begin
                if (!cand_reject) begin
                    wr_x_d = cand_x_q;
                    wr_y_d = cand_y_q;
                end
            end
            PLACE: begin
                placed_d = placed_q + 1'b1;
                if (last_mine) begin
                    rd_x_d = '0;
                    rd_y_d = '0;
                    wr_x_d = '0;
                    wr_y_d = '0;
                end
            end
            SCAN: begin
                if (!scan_last) begin
                    rd_x_d = scan_x_next;
                    rd_y_d = scan_y_next;
                    wr_x_d = scan_x_next;
                    wr_y_d = scan_y_next;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == FINISH);
        boardClear  = (state_q == CLEAR);
        mineWriteEn = (state_q == PLACE);
        incAdjacent = (state_q == SCAN) && mineReadValue;
    end

    assign readX  = rd_x_q;
    assign readY  = rd_y_q;
    assign writeX = wr_x_q;
    assign writeY = wr_y_q;

endmodule

// File: tb/tb_mine_placer.sv
// Randomised scoreboard bench for mine_placer on an 8x8 board with 10 mines; includes the mine and count board models.
// Define SAFE_FIRST_CLICK_EN at compile time to exercise the safe-cell variant.
module tb_mine_placer;

    localparam int W = 8;
    localparam int H = 8;
    localparam int M = 10;

    typedef struct {
        int delta;
        int mines;
    } exp_build_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic       busy, done, boardClear, mineWriteEn, incAdjacent;
    logic [2:0] readX, readY, writeX, writeY;
    logic       mineReadValue;
`ifdef SAFE_FIRST_CLICK_EN
    logic [2:0] safeX = 3'd3;
    logic [2:0] safeY = 3'd4;
`endif

    logic mine_board [H][W];
    int   cnt_board  [H][W];
    bit   inject_mode = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [5:0] exp_place [$];
    logic [5:0] exp_inc   [$];
    exp_build_t exp_build [$];
    logic [15:0] trace    [$];
    bit   rec_en = 1'b0;

    int cyc = 0;
    int clear_cyc = 0;
    int clear_cnt = 0;
    int done_cnt  = 0;
    int inc_cnt   = 0;

    mine_placer #(.WIDTH(W), .HEIGHT(H), .MINES(M)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .seed          (seed),
`ifdef SAFE_FIRST_CLICK_EN
        .safeX         (safeX),
        .safeY         (safeY),
`endif
        .busy          (busy),
        .done          (done),
        .boardClear    (boardClear),
        .readX         (readX),
        .readY         (readY),
        .mineReadValue (mineReadValue),
        .writeX        (writeX),
        .writeY        (writeY),
        .mineWriteEn   (mineWriteEn),
        .incAdjacent   (incAdjacent)
    );

    always #5 clk = ~clk;

    assign mineReadValue = mine_board[readY][readX];

    // External boards: clear (or load the injected pattern), mine writes, neighbour increments.
    always @(posedge clk) begin
        if (boardClear) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    mine_board[y][x] <= inject_mode && ((x == 0 && y == 0) || (x == W-1 && y == H-1));
                    cnt_board[y][x]  <= 0;
                end
        end else begin
            if (mineWriteEn && !inject_mode) mine_board[writeY][writeX] <= 1'b1;
            if (incAdjacent) begin
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++) begin
                        int nx, ny;
                        nx = int'(writeX) + dx;
                        ny = int'(writeY) + dy;
                        if ((dx != 0 || dy != 0) && nx >= 0 && nx < W && ny >= 0 && ny < H)
                            cnt_board[ny][nx] <= cnt_board[ny][nx] + 1;
                    end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: replay the pick/reject rules with a plain LFSR and board array.
    task automatic build_expect(input logic [15:0] sd, input bit inject);
        bit          b [H][W];
        logic [15:0] s;
        int          picks, placed, x, y, mines;
        bit          rej;
        s = (sd == 16'h0000) ? 16'hACE1 : sd;
        picks = 0;
        placed = 0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) b[yy][xx] = 1'b0;
        if (inject) begin
            b[0][0] = 1'b1;
            b[H-1][W-1] = 1'b1;
        end
        while (placed < M && picks < 20000) begin
            picks++;
            x = int'(s) % 8;
            y = (int'(s) / 8) % 8;
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
            rej = (x >= W) || (y >= H) || b[y][x];
`ifdef SAFE_FIRST_CLICK_EN
            if (x == 3 && y == 4) rej = 1'b1;
`endif
            if (!rej) begin
                if (!inject) b[y][x] = 1'b1;
                exp_place.push_back({3'(x), 3'(y)});
                placed++;
            end
        end
        mines = 0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                if (b[yy][xx]) begin
                    exp_inc.push_back({3'(xx), 3'(yy)});
                    mines++;
                end
        exp_build.push_back('{delta: 2 * picks + M + W * H + 1, mines: mines});
    endtask

    task automatic end_check();
        exp_build_t eb;
        int mines, wrong, sum, nb;
        if (exp_build.size() == 0) begin
            chk("done_unexpected", 1, 0);
            return;
        end
        eb = exp_build.pop_front();
        chk("done_latency", cyc - clear_cyc, eb.delta);
        chk("busy_at_done", busy, 1);
        mines = 0;
        wrong = 0;
        sum = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (mine_board[y][x]) mines++;
                sum += cnt_board[y][x];
                nb = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if ((dx != 0 || dy != 0) && x+dx >= 0 && x+dx < W && y+dy >= 0 && y+dy < H)
                            if (mine_board[y+dy][x+dx]) nb++;
                if (nb != cnt_board[y][x]) wrong++;
            end
        chk("mine_count", mines, eb.mines);
        chk("inc_pulses", inc_cnt, eb.mines);
        chk("count_board_bad_cells", wrong, 0);
        if (inject_mode) chk("inject_count_sum", sum, 6);
`ifdef SAFE_FIRST_CLICK_EN
        chk("safe_cell_clear", mine_board[4][3], 0);
`endif
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe.
    always @(negedge clk) begin
        logic [5:0] e;
        cyc++;
        if (rec_en) trace.push_back({boardClear, mineWriteEn, incAdjacent, done, writeX, writeY, readX, readY});
        if (!reset) begin
            if (boardClear) begin
                clear_cyc = cyc;
                clear_cnt++;
                inc_cnt = 0;
            end
            if (mineWriteEn || incAdjacent) chk("strobe_exclusive", mineWriteEn && incAdjacent, 0);
            if (mineWriteEn) begin
                if (exp_place.size() == 0) chk("place_unexpected", 1, 0);
                else begin
                    e = exp_place.pop_front();
                    chk("place_xy", {writeX, writeY}, e);
                end
            end
            if (incAdjacent) begin
                inc_cnt++;
                if (exp_inc.size() == 0) chk("inc_unexpected", 1, 0);
                else begin
                    e = exp_inc.pop_front();
                    chk("inc_xy", {writeX, writeY}, e);
                end
            end
            if (done) begin
                done_cnt++;
                end_check();
            end
        end
    end

    task automatic wait_done(input int budget);
        int d0, n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [15:0] sd);
        @(negedge clk);
        seed  = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_build(input logic [15:0] sd, input bit inject);
        inject_mode = inject;
        build_expect(sd, inject);
        pulse_start(sd);
        wait_done(3000);
        inject_mode = 1'b0;
    endtask

    initial begin
        logic [15:0] t1 [$];
        logic [63:0] b1, b2;
        int diffs, d0, c0, n;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clear", boardClear, 0);
        chk("rst_we", mineWriteEn, 0);
        chk("rst_inc", incAdjacent, 0);
        chk("rst_coords", {readX, readY, writeX, writeY}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_build(16'h0001, 1'b0);
        chk("idle_after_done", busy, 0);

        // Seed 0 must behave exactly like the default seed.
        trace.delete();
        rec_en = 1'b1;
        run_build(16'h0000, 1'b0);
        rec_en = 1'b0;
        t1 = trace;
        for (int i = 0; i < 64; i++) b1[i] = mine_board[i / 8][i % 8];
        trace.delete();
        rec_en = 1'b1;
        run_build(16'hACE1, 1'b0);
        rec_en = 1'b0;
        for (int i = 0; i < 64; i++) b2[i] = mine_board[i / 8][i % 8];
        chk("trace_len_seed0", trace.size(), t1.size());
        diffs = 0;
        for (int i = 0; i < trace.size() && i < t1.size(); i++)
            if (trace[i] != t1[i]) diffs++;
        chk("trace_diff_seed0", diffs, 0);
        chk("mine_set_seed0_same", b1 == b2, 1);

`ifdef SAFE_FIRST_CLICK_EN
        for (int i = 0; i < 20; i++) run_build(16'($urandom_range(1, 65535)), 1'b0);
`else
        for (int i = 0; i < 5; i++) run_build(16'($urandom_range(1, 65535)), 1'b0);
`endif

        // Start pulsed mid-SCAN is ignored.
        d0 = done_cnt;
        c0 = clear_cnt;
        build_expect(16'h1234, 1'b0);
        pulse_start(16'h1234);
        n = 0;
        while (!incAdjacent && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_scan", incAdjacent, 1);
        pulse_start(16'h5555);
        wait_done(3000);
        repeat (5) @(negedge clk);
        chk("scan_start_done_pulses", done_cnt - d0, 1);
        chk("scan_start_clears", clear_cnt - c0, 1);
        chk("scan_start_idle", busy, 0);

        // Reset asserted mid-PLACE clears outputs without a clock edge.
        build_expect(16'hBEEF, 1'b0);
        pulse_start(16'hBEEF);
        n = 0;
        while (!mineWriteEn && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_place", mineWriteEn, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_we", mineWriteEn, 0);
        chk("async_rst_inc", incAdjacent, 0);
        exp_place.delete();
        exp_inc.delete();
        exp_build.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        c0 = clear_cnt;
        run_build(16'hBEEF, 1'b0);
        chk("restart_clears_once", clear_cnt - c0, 1);

        // Injected corner mines.
        run_build(16'h0001, 1'b1);

        chk("queues_drained", exp_place.size() + exp_inc.size() + exp_build.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
